// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, timeout default and measurement FSM states
package pwm_pkg;
  localparam int DEF_CNT_W       = 27;
  localparam int DEF_TIMEOUT_CYC = 2000000;
  localparam int DEF_PCT_W       = 7;
  typedef enum logic [1:0] {IDLE, MEAS, DIV} state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle
// ports: start loads dividend/divisor; busy while iterating; done pulses
// one cycle after the last bit, when quotient holds the result
module seq_divider #(
  parameter int DVD_W = 34,
  parameter int DVS_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);
  localparam int CW = $clog2(DVD_W + 1);
  logic [CW-1:0]    r_cnt;
  logic [DVS_W-1:0] r_rem, r_dvs;
  logic [DVD_W-1:0] r_q;
  logic             r_done;
  logic [DVS_W:0]   w_sh, w_diff;
  logic             w_ge;
  // remainder stays below the divisor, so the shifted trial fits DVS_W+1 bits
  assign w_sh     = {r_rem, r_q[DVD_W-1]};
  assign w_diff   = w_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[DVS_W];
  assign busy     = r_cnt != '0;
  assign done     = r_done;
  assign quotient = r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_q   <= dividend;
        r_rem <= '0;
        r_dvs <= divisor;
        r_cnt <= CW'(DVD_W);
      end else if (busy) begin
        r_rem  <= w_ge ? w_diff[DVS_W-1:0] : w_sh[DVS_W-1:0];
        r_q    <= {r_q[DVD_W-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
        r_done <= r_cnt == CW'(1);
      end
    end
endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and percent duty of an async PWM input
// ports: clk, restart_n (async active-low); pwm_in (async); duty_pct/period_cyc/
// high_cyc results with valid pulse; static_lvl after timeout; overrun on dropped capture
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int PCT_W       = DEF_PCT_W
) (
  input  logic             clk,
  input  logic             restart_n,
  input  logic             pwm_in,
  output logic [PCT_W-1:0] duty_pct,
  output logic [CNT_W-1:0] period_cyc,
  output logic [CNT_W-1:0] high_cyc,
  output logic             valid,
  output logic             static_lvl,
  output logic             overrun
);
  localparam int DVD_W = CNT_W + 7;
  state_t           r_state;
  logic             r_s1, r_s2, r_s3, r_to_done, r_valid, r_static, r_overrun;
  logic [CNT_W-1:0] r_per, r_hi, r_pcap, r_hcap, r_period, r_high;
  logic [PCT_W-1:0] r_duty;
  logic             w_rise, w_to, w_start, w_busy, w_done, w_per_sat;
  logic [DVD_W-1:0] w_dvd, w_q;
  logic [CNT_W-1:0] w_dvs;
  assign w_rise    = r_s2 & ~r_s3;
  assign w_per_sat = r_per == CNT_W'(TIMEOUT_CYC);
  // fires once per timeout entry; a rise in the same cycle takes priority
  assign w_to      = w_per_sat && !r_to_done && r_state != DIV && !w_rise;
  assign w_start   = w_rise && r_state != IDLE && !w_busy;
  // the rise cycle is cycle 0 of the next period, hence the +1
  assign w_dvs     = r_per + CNT_W'(1);
  assign w_dvd     = DVD_W'(r_hi) * DVD_W'(100);
  seq_divider #(.DVD_W(DVD_W), .DVS_W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (restart_n),
    .start    (w_start),
    .dividend (w_dvd),
    .divisor  (w_dvs),
    .busy     (w_busy),
    .done     (w_done),
    .quotient (w_q)
  );
  always_ff @(posedge clk or negedge restart_n)
    if (!restart_n) begin
      {r_s1, r_s2, r_s3} <= '0;
      r_state   <= IDLE;
      r_per     <= '0;
      r_hi      <= '0;
      r_pcap    <= '0;
      r_hcap    <= '0;
      r_to_done <= 1'b0;
      r_duty    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_static  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      {r_s1, r_s2, r_s3} <= {pwm_in, r_s1, r_s2};
      r_per     <= w_rise ? '0 : w_per_sat ? r_per : r_per + CNT_W'(1);
      // hi only advances alongside per, so it never exceeds per
      r_hi      <= w_rise ? '0 : (r_s3 && !w_per_sat) ? r_hi + CNT_W'(1) : r_hi;
      r_to_done <= w_rise ? 1'b0 : w_to ? 1'b1 : r_to_done;
      r_overrun <= w_rise && r_state != IDLE && w_busy;
      r_valid   <= w_done || w_to;
      r_state   <= w_rise ? (r_state == IDLE ? MEAS : w_start ? DIV : r_state) :
                   w_to ? IDLE : w_done ? MEAS : r_state;
      if (w_start) begin
        r_pcap <= w_dvs;
        r_hcap <= r_hi;
      end
      if (w_done) begin
        r_duty   <= w_q > DVD_W'(100) ? PCT_W'(100) : PCT_W'(w_q);
        r_period <= r_pcap;
        r_high   <= r_hcap;
        r_static <= 1'b0;
      end else if (w_to) begin
        r_duty   <= r_s3 ? PCT_W'(100) : '0;
        r_period <= '0;
        r_high   <= '0;
        r_static <= 1'b1;
      end
    end
  assign duty_pct   = r_duty;
  assign period_cyc = r_period;
  assign high_cyc   = r_high;
  assign valid      = r_valid;
  assign static_lvl = r_static;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: randomized and directed PWM waveforms against a period-level model
module tb_pwm_duty_meter;
  localparam int CW = 16, TO = 1000, PW = 7;
  logic clk = 1'b0, restart_n = 1'b0, pwm_in = 1'b0;
  logic [PW-1:0] duty_pct;
  logic [CW-1:0] period_cyc, high_cyc;
  logic valid, static_lvl, overrun;
  typedef struct {int duty; int per; int hi; int st;} res_t;
  res_t got[$], exp_q[$];
  int checks = 0, errors = 0, ovr_got = 0, ovr_exp = 0, acc = 1 << 20;
  always #5 clk = ~clk;
  pwm_duty_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO), .PCT_W(PW)) dut (
    .clk        (clk),
    .restart_n  (restart_n),
    .pwm_in     (pwm_in),
    .duty_pct   (duty_pct),
    .period_cyc (period_cyc),
    .high_cyc   (high_cyc),
    .valid      (valid),
    .static_lvl (static_lvl),
    .overrun    (overrun)
  );
  always @(negedge clk) begin
    if (valid) got.push_back(res_t'{int'(duty_pct), int'(period_cyc), int'(high_cyc), int'(static_lvl)});
    if (overrun) ovr_got++;
  end
  task automatic chk(input string tag, input int obs, input int e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // one period of the waveform; a capture is dropped if the previous accepted
  // one was fewer than CW+8 cycles earlier (divider still busy)
  task automatic drive_period(input int h, input int p);
    int d;
    pwm_in = 1'b1;
    cyc(h);
    pwm_in = 1'b0;
    cyc(p - h);
    acc += p;
    d = (h * 100) / p;
    if (acc >= CW + 8) begin
      exp_q.push_back(res_t'{d > 100 ? 100 : d, p, h, 0});
      acc = 0;
    end else ovr_exp++;
  endtask
  // closing rise ends the last period, then the input goes static at lvl
  task automatic close_to(input logic lvl);
    pwm_in = 1'b1;
    cyc(40);
    pwm_in = lvl;
    cyc(lvl ? 1460 : 1100);
    exp_q.push_back(res_t'{lvl ? 100 : 0, 0, 0, 1});
    acc = 1 << 20;
  endtask
  task automatic check_block(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, "_duty"}, got[i].duty, exp_q[i].duty);
      chk({tag, "_period"}, got[i].per, exp_q[i].per);
      chk({tag, "_high"}, got[i].hi, exp_q[i].hi);
      chk({tag, "_static"}, got[i].st, exp_q[i].st);
    end
    chk({tag, "_overruns"}, ovr_got, ovr_exp);
    got.delete();
    exp_q.delete();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, int'(duty_pct), 0);
    chk({tag, "_period"}, int'(period_cyc), 0);
    chk({tag, "_high"}, int'(high_cyc), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_static"}, int'(static_lvl), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask
  initial begin
    cyc(3);
    chk_zero("reset");
    restart_n = 1'b1;
    cyc(1100);
    exp_q.push_back(res_t'{0, 0, 0, 1});
    check_block("idle_timeout");
    repeat (3) drive_period(60, 200);
    close_to(1'b0);
    check_block("duty30");
    drive_period(299, 300);
    drive_period(1, 300);
    close_to(1'b0);
    check_block("trunc");
    for (int b = 0; b < 4; b++) begin
      int n, p, h;
      n = $urandom_range(2, 4);
      for (int k = 0; k < n; k++) begin
        p = $urandom_range(30, 300);
        h = $urandom_range(1, p - 1);
        drive_period(h, p);
      end
      close_to(1'b0);
      check_block("random");
    end
    repeat (8) drive_period(10, 20);
    close_to(1'b0);
    check_block("short_period");
    repeat (2) drive_period(100, 400);
    repeat (2) drive_period(300, 400);
    close_to(1'b0);
    check_block("step");
    repeat (2) drive_period(60, 200);
    close_to(1'b1);
    check_block("hold_high");
    pwm_in = 1'b0;
    cyc(1200);
    chk("quiet_after_static", got.size(), 0);
    pwm_in = 1'b1;
    cyc(60);
    pwm_in = 1'b0;
    cyc(140);
    pwm_in = 1'b1;
    cyc(13);
    #2 restart_n = 1'b0;
    pwm_in = 1'b0;
    #1 chk_zero("async_reset");
    chk("reset_no_valid", got.size(), 0);
    cyc(3);
    restart_n = 1'b1;
    acc = 1 << 20;
    repeat (2) drive_period(60, 200);
    close_to(1'b0);
    check_block("post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Decoder counterpart of the PWM generator. Samples a PWM waveform on an asynchronous input, measures high time and period in clock cycles, and computes integer duty cycle in percent.
The result feeds the existing seven-segment and VGA paths in place of, or beside, the commanded duty value. This closes the loop so the team can check the generated PWM against its setpoint.

Parameters:
CNT_W, 27, width of the high-time and period counters (matches the existing duty bus width)
TIMEOUT_CYC, 2000000, cycles with no rising edge before the input is declared static
PCT_W, 7, width of the percent result (0..100)

Ports:
clk  input  1  system clock; all state is synchronous to its rising edge
restart_n  input  1  asynchronous, active-low reset
pwm_in  input  1  PWM waveform under measurement; asynchronous to clk
duty_pct  output  PCT_W  last computed duty cycle, percent, 0..100
period_cyc  output  CNT_W  last measured period in clk cycles
high_cyc  output  CNT_W  last measured high time in clk cycles
valid  output  1  one-cycle pulse when duty_pct, period_cyc and high_cyc update
static_lvl  output  1  1 while the input is declared static (timeout); cleared on the next valid measured result
overrun  output  1  one-cycle pulse when a period completes while the divider is busy

Behaviour:
- Reset (restart_n low, asynchronous): all outputs 0; synchronizer flops 0; state IDLE; counters 0. Release is synchronous to clk.
- Input conditioning:
  - 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from pwm_in to rise/fall is 3 cycles. It is excluded from all counts, and is equal for both edges, so counts are exact.
- State machine:
  - IDLE: wait for rise. On rise, clear per_cnt and hi_cnt, go to MEAS.
  - MEAS:
    - per_cnt increments every cycle.
    - hi_cnt increments while s3 = 1.
    - On the next rise:
      - Latch period_cap = per_cnt + 1 and high_cap = hi_cnt.
      - Restart both counters. The edge cycle counts as cycle 0 of the new period.
      - Go to DIV if the divider is idle; otherwise pulse overrun and discard the capture.
  - DIV:
    - Counting continues in parallel, so the measurement runs concurrently.
    - The divider computes (high_cap*100)/period_cap.
    - On done, register the outputs and pulse valid in the same cycle, then return to MEAS.
- Arithmetic:
  - Dividend width is CNT_W+7. The divider is restoring, 1 quotient bit per cycle, CNT_W+7 cycles.
  - Quotient is truncated toward zero and clamped to 100.
  - period_cap is never 0 (minimum 1).
  - hi_cnt saturates at per_cnt, so high_cap <= period_cap and 100% is reached only for a continuously high input.
- Timeout:
  - If per_cnt reaches TIMEOUT_CYC in MEAS or IDLE: duty_pct = 100 if s3 = 1, else 0; period_cyc = 0; high_cyc = 0; static_lvl = 1; pulse valid once.
  - Then enter IDLE, which requires a fresh rise plus a full period before the next result.
  - per_cnt saturates and does not wrap.
  - In IDLE, the timeout counter runs only after reset; valid pulses once per timeout entry, not repeatedly.
- Simultaneous events:
  - Rise and timeout in the same cycle: rise wins.
  - Divider done and new rise in the same cycle: outputs update and the new capture starts a new DIV. This is not an overrun.
- Minimum measurable period is CNT_W+8 cycles. Shorter periods cause overrun on alternate periods, but the results reported are still exact.

Decomposition:
- Shared package (pwm_pkg): CNT_W, PCT_W, TIMEOUT_CYC defaults, state encoding constants (IDLE, MEAS, DIV).
- One sub-module: seq_divider. Ports are start, dividend, divisor, busy, done, quotient. It is reusable by the display path.

Test Plan:
- CNT_W=16, TIMEOUT_CYC=1000; pwm_in period 200, high 60 -> after the 2nd rise plus 23 cycles, valid with duty_pct=30, period_cyc=200, high_cyc=60.
- Period 300, high 299 -> duty_pct=99 (truncation); high 1 -> duty_pct=0.
- pwm_in held high for 1500 cycles after a valid period -> one valid pulse with duty_pct=100, static_lvl=1; held low -> duty_pct=0. No further valid pulses until the input toggles.
- Period 20 (below the 24-cycle minimum), high 10 -> overrun pulses on alternate periods; every valid reports duty_pct=50, period_cyc=20.
- restart_n asserted mid-DIV -> all outputs 0 immediately (asynchronous) with no valid pulse; after release, the first result requires two rising edges.
- Duty changes 25% -> 75% at a period boundary (period 400) -> consecutive valid results report 25 then 75, with no intermediate value.
